task1_rom: RTL and testbench
============================

Name: task1_rom

Overview:
- Read-only program memory holding the fixed instruction image for Task 1 of the 10-bit teaching CPU.
- The CPU fetch stage drives a 10-bit word address. The block returns the 10-bit instruction word stored there.
- The output is registered on the clock so the block drops into a synchronous fetch stage.
- The contents are fixed at elaboration. There is no write path.

Parameters:
- DATA_W, 10, instruction word width in bits.
- ADDR_W, 10, address width in bits.
- DEPTH, 1024, number of words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- address  input  ADDR_W  word address to fetch.
- read_data  output  DATA_W  registered instruction word.

Behaviour:
- Interface rule: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - When rst_n falls, read_data goes to 10'b0000000000 immediately, without waiting for a clock edge. This value encodes a nop.
  - While rst_n stays low, read_data holds zero and clock edges are ignored.
- Read:
  - On each rising clk with rst_n high, read_data <= memory[address].
  - Latency is exactly 1 cycle: an address presented before edge N appears on read_data after edge N.
  - read_data holds its value between edges, even if address changes mid-cycle.
- Reset release: the first rising edge after rst_n rises loads memory[address] as normal. There is no extra dead cycle.
- Address range: all 1024 addresses are valid. There is no wrap-around or out-of-range case.
- Contents, binary, fixed:
  - 0: 0000000001 (sub t0,t0,t0: clear t0)
  - 1: 1101010000 (load s0, 0(s0))
  - 2: 1101011001 (load s1, 1(s0))
  - 3: 0000000000 (nop, wait for the register write)
  - 4: 0110100000 (add t1,t0,t1)
  - 5: 1110110011 (store result, 2(s0))
  - 6: 0010000010 (halt)
  - 7 to 1023: 0000000000
- Consecutive identical addresses return the same word every cycle.
- The block has no enable, no handshake and no error output.

Test Plan:
1. Assert rst_n=0 mid-cycle while read_data holds 1101010000 -> read_data becomes 0000000000 before the next clk edge and stays 0 for 3 edges while rst_n remains low.
2. Release rst_n with address=0, then present addresses 0, 1, 2 on successive cycles (10 ns period) -> read_data reads 0000000001, 1101010000, 1101011001, each one cycle after its address.
3. Sweep addresses 3 to 6 -> read_data reads 0000000000, 0110100000, 1110110011, 0010000010.
4. Apply addresses 7, 512 and 1023 -> read_data reads 0000000000 each time.
5. Change address from 2 to 6 halfway between edges -> read_data keeps 1101011001 until the next rising edge, then shows 0010000010.
6. Apply address 5 followed by a random address sequence against a golden model -> every read_data matches the word at the address presented on the previous edge.

Source files
------------

// File: rtl/task1_rom.sv
// Purpose : fixed instruction image for Task 1 of the 10-bit teaching CPU.
// Latency : 1 cycle, so the word addressed before edge N appears after edge N.
// Backpres: none; a new address is accepted every cycle and there is no stall input.
//
// Ports:
//   clk        - system clock, rising-edge active
//   rst_n      - asynchronous active-low reset; forces read_data to the nop word 0
//   address    - word address driven by the fetch stage
//   read_data  - registered instruction word
module task1_rom #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] read_data
);

    // The decode below covers the full address space only when DEPTH matches it.
    if (DEPTH != (2 ** ADDR_W)) begin : g_depth_check
        $error("task1_rom: DEPTH must equal 2**ADDR_W");
    end

    logic [DATA_W-1:0] read_data_d;
    logic [DATA_W-1:0] read_data_q;

    // Program image. Every address outside 0..6 holds the nop word.
    always_comb begin
        read_data_d = '0;
        case (address)
            ADDR_W'(0): read_data_d = DATA_W'(10'b0000000001); // sub t0,t0,t0
            ADDR_W'(1): read_data_d = DATA_W'(10'b1101010000); // load s0, 0(s0)
            ADDR_W'(2): read_data_d = DATA_W'(10'b1101011001); // load s1, 1(s0)
            ADDR_W'(3): read_data_d = DATA_W'(10'b0000000000); // nop, register write settles
            ADDR_W'(4): read_data_d = DATA_W'(10'b0110100000); // add t1,t0,t1
            ADDR_W'(5): read_data_d = DATA_W'(10'b1110110011); // store result, 2(s0)
            ADDR_W'(6): read_data_d = DATA_W'(10'b0010000010); // halt
            default:    read_data_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;

endmodule

// File: tb/tb_task1_rom.sv
module tb_task1_rom;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] read_data;

    int n_cmp;
    int n_err;
    bit cmp_en;

    logic [DATA_W-1:0] golden [DEPTH];
    logic [DATA_W-1:0] exp_word;

    task1_rom #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .read_data(read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program table as written in the Task 1 listing.
    initial begin
        for (int i = 0; i < DEPTH; i++) golden[i] = '0;
        golden[0] = 10'b0000000001;
        golden[1] = 10'b1101010000;
        golden[2] = 10'b1101011001;
        golden[3] = 10'b0000000000;
        golden[4] = 10'b0110100000;
        golden[5] = 10'b1110110011;
        golden[6] = 10'b0010000010;
    end

    // Expected output: the word at the address seen on the last edge, or zero
    // whenever reset has been asserted since then.
    initial exp_word = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_word <= '0;
        else        exp_word <= golden[address];
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Continuous comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) check("model", read_data, exp_word);
    end

    // Present an address (called at posedge+2), then check the word after the next edge.
    task automatic step(input int a, input logic [DATA_W-1:0] req, input string name);
        address = ADDR_W'(a);
        @(posedge clk);
        #1;
        check(name, read_data, req);
        #1;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        cmp_en  = 1'b0;
        rst_n   = 1'b1;
        address = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_value", read_data, 10'b0000000000);
        cmp_en = 1'b1;

        // Bring the DUT up and load word 1 so reset has something to clear.
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1, 10'b1101010000, "pre_reset_word1");

        // 1: mid-cycle async reset, then three ignored edges.
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", read_data, 10'b0000000000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("reset_hold", read_data, 10'b0000000000);
        end
        #1;

        // 2: release with address 0, then 0, 1, 2.
        rst_n = 1'b1;
        step(0, 10'b0000000001, "addr0_after_release");
        step(1, 10'b1101010000, "addr1");
        step(2, 10'b1101011001, "addr2");

        // 3: sweep 3..6.
        step(3, 10'b0000000000, "addr3");
        step(4, 10'b0110100000, "addr4");
        step(5, 10'b1110110011, "addr5");
        step(6, 10'b0010000010, "addr6");

        // 4: unused space reads as nop.
        step(7,    10'b0000000000, "addr7");
        step(512,  10'b0000000000, "addr512");
        step(1023, 10'b0000000000, "addr1023");

        // Repeated address returns the same word each cycle.
        step(4, 10'b0110100000, "repeat4_a");
        step(4, 10'b0110100000, "repeat4_b");

        // 5: address changes between edges; output must not follow until the edge.
        step(2, 10'b1101011001, "midcycle_base");
        #2;
        address = ADDR_W'(6);
        #1;
        check("midcycle_hold", read_data, 10'b1101011001);
        @(posedge clk);
        #1;
        check("midcycle_update", read_data, 10'b0010000010);
        #1;

        // 6: address 5, then random addresses checked by the model process.
        step(5, 10'b1110110011, "rand_lead_addr5");
        for (int k = 0; k < 300; k++) begin
            if (k % 4 == 0) address = ADDR_W'($urandom_range(0, 7));
            else            address = ADDR_W'($urandom_range(0, DEPTH - 1));
            @(posedge clk);
            #2;
        end

        @(posedge clk);
        #2;
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
